// File: rtl/morse_pkg.sv
// ============================================================================
// Module   : morse_pkg
// Brief    : Element codes, receiver FSM states and default bytes for Morse RX.
// Revision : 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_DOT  = 3'b001;
    localparam logic [2:0] CODE_DASH = 3'b010;
    localparam logic [2:0] CODE_CHAR = 3'b011;
    localparam logic [2:0] CODE_WORD = 3'b100;

    localparam logic [7:0] SPACE_CHAR_DEF   = 8'h20;
    localparam logic [7:0] UNKNOWN_CHAR_DEF = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COLLECT    = 2'd1,
        ST_EMIT       = 2'd2,
        ST_SPACE_EMIT = 2'd3
    } morse_state_t;

endpackage

`default_nettype wire

// File: rtl/morse_rx_decoder_if.sv
// ============================================================================
// Module   : morse_rx_decoder_if
// Brief    : Element-code input, decoded byte channel and status of Morse RX.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface morse_rx_decoder_if;

    logic [2:0] code_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_unknown;
    logic       overrun;
    logic       clr_overrun;

    // master is the decoder: it consumes codes and produces bytes
    modport master (
        input  code_in,
        input  out_ready,
        input  clr_overrun,
        output out_data,
        output out_valid,
        output err_unknown,
        output overrun
    );

    modport slave (
        output code_in,
        output out_ready,
        output clr_overrun,
        input  out_data,
        input  out_valid,
        input  err_unknown,
        input  overrun
    );

endinterface

`default_nettype wire

// File: rtl/morse_lut.sv
// ============================================================================
// Module   : morse_lut
// Brief    : Combinational Morse symbol to ASCII table (A-Z, 0-9).
// Revision : 1.0
// ============================================================================
`default_nettype none

module morse_lut #(
    parameter int MAX_ELEMS = 5
) (
    input  wire logic [MAX_ELEMS-1:0] pattern,
    input  wire logic [2:0]           len,
    output logic      [7:0]           ascii,
    output logic                      hit
);

    logic       w_upper_zero;
    logic [7:0] w_key;
    logic [7:0] w_ascii;

    // Table symbols are at most five elements; any higher bit set means no match
    generate
        if (MAX_ELEMS > 5) begin : g_upper
            assign w_upper_zero = ~|pattern[MAX_ELEMS-1:5];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    // Key is {len, pattern}; bit i of pattern is element i, dash = 1
    assign w_key = {len, pattern[4:0]};

    always_comb begin
        w_ascii = 8'h00;
        case (w_key)
            {3'd2, 5'd2}:  w_ascii = "A";
            {3'd4, 5'd1}:  w_ascii = "B";
            {3'd4, 5'd5}:  w_ascii = "C";
            {3'd3, 5'd1}:  w_ascii = "D";
            {3'd1, 5'd0}:  w_ascii = "E";
            {3'd4, 5'd4}:  w_ascii = "F";
            {3'd3, 5'd3}:  w_ascii = "G";
            {3'd4, 5'd0}:  w_ascii = "H";
            {3'd2, 5'd0}:  w_ascii = "I";
            {3'd4, 5'd14}: w_ascii = "J";
            {3'd3, 5'd5}:  w_ascii = "K";
            {3'd4, 5'd2}:  w_ascii = "L";
            {3'd2, 5'd3}:  w_ascii = "M";
            {3'd2, 5'd1}:  w_ascii = "N";
            {3'd3, 5'd7}:  w_ascii = "O";
            {3'd4, 5'd6}:  w_ascii = "P";
            {3'd4, 5'd11}: w_ascii = "Q";
            {3'd3, 5'd2}:  w_ascii = "R";
            {3'd3, 5'd0}:  w_ascii = "S";
            {3'd1, 5'd1}:  w_ascii = "T";
            {3'd3, 5'd4}:  w_ascii = "U";
            {3'd4, 5'd8}:  w_ascii = "V";
            {3'd3, 5'd6}:  w_ascii = "W";
            {3'd4, 5'd9}:  w_ascii = "X";
            {3'd4, 5'd13}: w_ascii = "Y";
            {3'd4, 5'd3}:  w_ascii = "Z";
            {3'd5, 5'd31}: w_ascii = "0";
            {3'd5, 5'd30}: w_ascii = "1";
            {3'd5, 5'd28}: w_ascii = "2";
            {3'd5, 5'd24}: w_ascii = "3";
            {3'd5, 5'd16}: w_ascii = "4";
            {3'd5, 5'd0}:  w_ascii = "5";
            {3'd5, 5'd1}:  w_ascii = "6";
            {3'd5, 5'd3}:  w_ascii = "7";
            {3'd5, 5'd7}:  w_ascii = "8";
            {3'd5, 5'd15}: w_ascii = "9";
            default:       w_ascii = 8'h00;
        endcase
    end

    assign hit   = (w_ascii != 8'h00) && w_upper_zero;
    assign ascii = w_ascii;

endmodule

`default_nettype wire

// File: rtl/morse_rx_decoder.sv
// ============================================================================
// Module   : morse_rx_decoder
// Brief    : Accumulates Morse elements, decodes symbols to ASCII on a
//            valid/ready byte channel with word-space and overrun handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int         MAX_ELEMS    = 5,
    parameter logic [7:0] SPACE_CHAR   = SPACE_CHAR_DEF,
    parameter logic [7:0] UNKNOWN_CHAR = UNKNOWN_CHAR_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    morse_rx_decoder_if.master  bus
);

    localparam logic [2:0] c_MAX_LEN = 3'(MAX_ELEMS);

    morse_state_t         r_state,     w_state_next;
    logic [MAX_ELEMS-1:0] r_pattern,   w_pattern_next;
    logic [2:0]           r_len,       w_len_next;
    logic                 r_too_long,  w_too_long_next;
    logic                 r_space_pend, w_space_pend_next;
    logic [7:0]           r_out_data,  w_out_data_next;
    logic                 r_out_valid, w_out_valid_next;
    logic                 r_err,       w_err_next;
    logic                 r_overrun,   w_overrun_next;

    logic       w_elem, w_boundary, w_word_space, w_illegal;
    logic       w_holding, w_avail;
    logic       w_load, w_load_space_pend, w_load_unknown, w_drop;
    logic [7:0] w_ascii, w_dec_byte;
    logic       w_hit;

    morse_lut #(.MAX_ELEMS(MAX_ELEMS)) u_lut (
        .pattern (r_pattern),
        .len     (r_len),
        .ascii   (w_ascii),
        .hit     (w_hit)
    );

    always_comb begin
        w_elem       = (bus.code_in == CODE_DOT) || (bus.code_in == CODE_DASH);
        w_boundary   = ((bus.code_in == CODE_CHAR) || (bus.code_in == CODE_WORD)) && (r_len != 3'd0);
        w_word_space = (bus.code_in == CODE_WORD) && (r_len == 3'd0);
        w_illegal    = (bus.code_in > CODE_WORD);
        w_holding    = (r_state == ST_EMIT) || (r_state == ST_SPACE_EMIT);
        w_avail      = !w_holding || bus.out_ready;
        w_dec_byte   = (r_too_long || !w_hit) ? UNKNOWN_CHAR : w_ascii;

        w_pattern_next  = r_pattern;
        w_len_next      = r_len;
        w_too_long_next = r_too_long;
        if (w_elem) begin
            if (r_len == c_MAX_LEN) begin
                w_too_long_next = 1'b1;
            end else begin
                w_pattern_next[r_len] = (bus.code_in == CODE_DASH);
                w_len_next            = r_len + 3'd1;
            end
        end else if (w_boundary) begin
            w_pattern_next  = '0;
            w_len_next      = 3'd0;
            w_too_long_next = 1'b0;
        end

        w_load            = 1'b0;
        w_load_space_pend = 1'b0;
        w_load_unknown    = 1'b0;
        w_drop            = 1'b0;
        w_out_data_next   = r_out_data;
        w_space_pend_next = r_space_pend;
        if (w_boundary) begin
            // A space still owed to the previous word must precede this char
            if (r_space_pend) begin
                w_drop = 1'b1;
                if (w_avail) begin
                    w_load            = 1'b1;
                    w_load_space_pend = 1'b1;
                    w_out_data_next   = SPACE_CHAR;
                    w_space_pend_next = 1'b0;
                end
            end else if (w_avail) begin
                w_load          = 1'b1;
                w_load_unknown  = (w_dec_byte == UNKNOWN_CHAR);
                w_out_data_next = w_dec_byte;
            end else begin
                w_drop = 1'b1;
            end
            if (bus.code_in == CODE_WORD) begin
                w_space_pend_next = 1'b1;
            end
        end else if (w_word_space) begin
            if (w_avail) begin
                w_load            = 1'b1;
                w_load_space_pend = r_space_pend;
                w_out_data_next   = SPACE_CHAR;
            end else if (r_space_pend) begin
                w_drop = 1'b1;
            end else begin
                w_space_pend_next = 1'b1;
            end
        end else if (r_space_pend && w_avail) begin
            w_load            = 1'b1;
            w_load_space_pend = 1'b1;
            w_out_data_next   = SPACE_CHAR;
            w_space_pend_next = 1'b0;
        end

        w_out_valid_next = w_load || (w_holding && !bus.out_ready);
        w_err_next       = w_load_unknown || w_illegal;
        w_overrun_next   = w_drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : r_overrun);

        if (w_load) begin
            w_state_next = w_load_space_pend ? ST_SPACE_EMIT : ST_EMIT;
        end else if (w_holding && !bus.out_ready) begin
            w_state_next = r_state;
        end else begin
            w_state_next = (w_len_next != 3'd0) ? ST_COLLECT : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pattern    <= '0;
            r_len        <= 3'd0;
            r_too_long   <= 1'b0;
            r_space_pend <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pattern    <= w_pattern_next;
            r_len        <= w_len_next;
            r_too_long   <= w_too_long_next;
            r_space_pend <= w_space_pend_next;
            r_out_data   <= w_out_data_next;
            r_out_valid  <= w_out_valid_next;
            r_err        <= w_err_next;
            r_overrun    <= w_overrun_next;
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.err_unknown = r_err;
    assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire
